ins_cache_refill_ctrl: RTL



---
 rtl/ins_cache_refill_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ins_cache_refill_ctrl.sv
// Pages the program image from DDR into the instruction cache: initial load after reset,
// sequential refill at the end of the resident page, and target-page load on a jump.
module ins_cache_refill_ctrl #(
   parameter int ADDR_WIDTH_MEM  = 16,
   parameter int ISA_DEPTH       = 64,
   parameter int TOTAL_ISA_DEPTH = 128,
   parameter int DDR_ADDR_WIDTH  = 28,
   parameter int INS_WIDTH       = 64,
   parameter int ISA_BASE_ADDR   = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_WIDTH_MEM-1:0]    addr_ins,
   input  logic                         jmp_valid,
   input  logic [DDR_ADDR_WIDTH-1:0]    jmp_addr,
   output logic                         ins_cache_rdy,
   output logic                         ins_cache_inited,
   output logic [9:0]                   load_times,
   output logic                         ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0]    ddr_rd_addr,
   output logic [ADDR_WIDTH_MEM-1:0]    ddr_rd_len,
   input  logic                         ddr_rd_gnt,
   input  logic                         ddr_rd_valid,
   input  logic [INS_WIDTH-1:0]         ddr_rd_data,
   output logic                         cache_wr_en,
   output logic [$clog2(ISA_DEPTH)-1:0] cache_wr_addr,
   output logic [INS_WIDTH-1:0]         cache_wr_data
);

   localparam int CW         = $clog2(ISA_DEPTH);
   localparam int PAGE_SHIFT = 3 + CW;
   localparam logic [31:0] DEPTH32 = 32'(ISA_DEPTH);
   localparam logic [31:0] TOTAL32 = 32'(TOTAL_ISA_DEPTH);

   typedef enum logic [2:0] {INIT, IDLE, REQ, FILL, DONE} state_t;

   state_t                      state_q;
   logic [9:0]                  page_q;
   logic [9:0]                  loadTimes_q;
   logic [ADDR_WIDTH_MEM-1:0]   beatCnt_q;
   logic                        rdy_q;
   logic                        inited_q;
   logic                        req_q;
   logic [DDR_ADDR_WIDTH-1:0]   rdAddr_q;
   logic [ADDR_WIDTH_MEM-1:0]   rdLen_q;
   logic                        wrEn_q;
   logic [CW-1:0]               wrAddr_q;
   logic [INS_WIDTH-1:0]        wrData_q;
   logic                        jmpPend_q;
   logic [DDR_ADDR_WIDTH-1:0]   jmpAddr_q;

   logic                        jmpActive;
   logic [DDR_ADDR_WIDTH-1:0]   jmpTarget;
   logic [31:0]                 jmpPage;
   logic                        jmpOk;
   logic                        seqOk;
   logic                        start_d;
   logic [9:0]                  page_d;

   function automatic logic [DDR_ADDR_WIDTH-1:0] pageAddr(input logic [9:0] page);
      pageAddr = DDR_ADDR_WIDTH'(ISA_BASE_ADDR) + DDR_ADDR_WIDTH'({22'd0, page} * DEPTH32 * 32'd8);
   endfunction

   // The final page may be shorter than a full cache page.
   function automatic logic [ADDR_WIDTH_MEM-1:0] pageLen(input logic [9:0] page);
      logic [31:0] rem;
      rem     = TOTAL32 - {22'd0, page} * DEPTH32;
      pageLen = (rem < DEPTH32) ? ADDR_WIDTH_MEM'(rem) : ADDR_WIDTH_MEM'(DEPTH32);
   endfunction

   // A live jump overrides a latched one; a jump, even a rejected one, masks the sequential check.
   always_comb begin
      jmpActive = jmp_valid | jmpPend_q;
      jmpTarget = jmp_valid ? jmp_addr : jmpAddr_q;
      jmpPage   = 32'(jmpTarget >> PAGE_SHIFT);
      jmpOk     = jmpActive && ((jmpPage + 32'd1) != {22'd0, loadTimes_q})
                  && ((jmpPage * DEPTH32) < TOTAL32);
      seqOk     = !jmpActive && (32'(addr_ins) == ({22'd0, loadTimes_q} * DEPTH32))
                  && (32'(addr_ins) < TOTAL32);
      page_d    = jmpActive ? jmpPage[9:0] : loadTimes_q;
      start_d   = jmpOk | seqOk;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         page_q      <= '0;
         loadTimes_q <= '0;
         beatCnt_q   <= '0;
         rdy_q       <= 1'b0;
         inited_q    <= 1'b0;
         req_q       <= 1'b0;
         rdAddr_q    <= '0;
         rdLen_q     <= '0;
         wrEn_q      <= 1'b0;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
         jmpPend_q   <= 1'b0;
         jmpAddr_q   <= '0;
      end else begin
         wrEn_q <= 1'b0;
         if (state_q != IDLE && jmp_valid) begin
            jmpPend_q <= 1'b1;
            jmpAddr_q <= jmp_addr;
         end
         case (state_q)
            INIT: begin
               page_q   <= '0;
               req_q    <= 1'b1;
               rdy_q    <= 1'b0;
               rdAddr_q <= pageAddr(10'd0);
               rdLen_q  <= pageLen(10'd0);
               state_q  <= REQ;
            end
            IDLE: begin
               jmpPend_q <= 1'b0;
               if (start_d) begin
                  page_q   <= page_d;
                  req_q    <= 1'b1;
                  rdy_q    <= 1'b0;
                  rdAddr_q <= pageAddr(page_d);
                  rdLen_q  <= pageLen(page_d);
                  state_q  <= REQ;
               end
            end
            REQ: begin
               if (ddr_rd_gnt) begin
                  req_q   <= 1'b0;
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (ddr_rd_valid) begin
                  wrEn_q    <= 1'b1;
                  wrAddr_q  <= beatCnt_q[CW-1:0];
                  wrData_q  <= ddr_rd_data;
                  beatCnt_q <= beatCnt_q + ADDR_WIDTH_MEM'(1);
                  if (beatCnt_q == rdLen_q - ADDR_WIDTH_MEM'(1)) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               loadTimes_q <= page_q + 10'd1;
               inited_q    <= 1'b1;
               rdy_q       <= 1'b1;
               beatCnt_q   <= '0;
               state_q     <= IDLE;
            end
            default: state_q <= INIT;
         endcase
      end
   end

   assign ins_cache_rdy    = rdy_q;
   assign ins_cache_inited = inited_q;
   assign load_times       = loadTimes_q;
   assign ddr_rd_req       = req_q;
   assign ddr_rd_addr      = rdAddr_q;
   assign ddr_rd_len       = rdLen_q;
   assign cache_wr_en      = wrEn_q;
   assign cache_wr_addr    = wrAddr_q;
   assign cache_wr_data    = wrData_q;

endmodule
